// File: rtl/ram_arbiter.sv
// ram_arbiter: sole owner of the byte-wide RAM port, shared between
// instruction fetch (IF), data load (LD) and data store (ST).
// Each 1/2/4-byte request becomes consecutive byte accesses.
// Read bytes are reassembled little-endian, and each requester gets a
// one-cycle done pulse.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (freeze), flush_in (kill fetch)
//   if_*  : fetch request/address, done pulse, 32-bit instruction
//   ld_*  : load request/address/size, done pulse, zero-extended data
//   st_*  : store request/address/size/data, done pulse
//   ram_* : byte address, write byte, write enable, read byte
//   busy_out : 10 serving IF, 01 serving LD/ST, 00 idle/turnaround
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  ld_req_in,
    input  logic [ADDR_WIDTH-1:0] ld_addr_in,
    input  logic [1:0]            ld_len_in,
    output logic                  ld_done_out,
    output logic [31:0]           ld_data_out,
    input  logic                  st_req_in,
    input  logic [ADDR_WIDTH-1:0] st_addr_in,
    input  logic [1:0]            st_len_in,
    input  logic [31:0]           st_data_in,
    output logic                  st_done_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_dout_out,
    output logic                  ram_wr_out,
    input  logic [7:0]            ram_din_in,
    output logic [1:0]            busy_out
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, TURN = 2'd3} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt, len, len_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [DW-1:0]         wbuf, wbuf_nxt, rbuf, rbuf_nxt;
    logic                  last_data, last_data_nxt, is_if, is_if_nxt;
    logic                  if_done_nxt, ld_done_nxt, st_done_nxt, ram_wr_nxt;
    logic [DW-1:0]         if_data_nxt, ld_data_nxt;
    logic [ADDR_WIDTH-1:0] ram_a_nxt;
    logic [7:0]            ram_dout_nxt;
    logic [1:0]            busy_nxt;

    logic [CW-1:0]         k;
    logic [DW-1:0]         rbuf_cap;
    logic                  if_ok, data_ok, grant_if, grant_data;

    function automatic logic [CW-1:0] len_to_n(input logic [1:0] code);
        return code[1] ? CW'(4) : (code[0] ? CW'(2) : CW'(1));
    endfunction

    // k = number of bytes completed once the current edge is taken
    assign k        = cnt + CW'(1);
    assign rbuf_cap = rbuf | (DW'(ram_din_in) << {cnt[1:0], 3'b000});

    // A flushed fetch is never granted; IF wins a tie only if data went last
    assign if_ok      = if_req_in && !flush_in;
    assign data_ok    = st_req_in || ld_req_in;
    assign grant_if   = if_ok && (!data_ok || last_data);
    assign grant_data = data_ok && !grant_if;

    // Next-state and registered-output computation
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        len_nxt       = len;
        base_nxt      = base;
        wbuf_nxt      = wbuf;
        rbuf_nxt      = rbuf;
        last_data_nxt = last_data;
        is_if_nxt     = is_if;
        if_done_nxt   = 1'b0;
        ld_done_nxt   = 1'b0;
        st_done_nxt   = 1'b0;
        if_data_nxt   = if_data_out;
        ld_data_nxt   = ld_data_out;
        ram_a_nxt     = ram_a_out;
        ram_dout_nxt  = ram_dout_out;
        ram_wr_nxt    = ram_wr_out;
        busy_nxt      = busy_out;

        case (state)
            IDLE: begin
                if (grant_if) begin
                    base_nxt      = if_addr_in;
                    len_nxt       = CW'(4);
                    is_if_nxt     = 1'b1;
                    last_data_nxt = 1'b0;
                    cnt_nxt       = '0;
                    rbuf_nxt      = '0;
                    ram_a_nxt     = if_addr_in;
                    ram_wr_nxt    = 1'b0;
                    busy_nxt      = 2'b10;
                    state_nxt     = RD;
                end else if (grant_data) begin
                    is_if_nxt     = 1'b0;
                    last_data_nxt = 1'b1;
                    cnt_nxt       = '0;
                    rbuf_nxt      = '0;
                    busy_nxt      = 2'b01;
                    if (st_req_in) begin
                        base_nxt     = st_addr_in;
                        len_nxt      = len_to_n(st_len_in);
                        wbuf_nxt     = st_data_in;
                        ram_a_nxt    = st_addr_in;
                        ram_dout_nxt = st_data_in[7:0];
                        ram_wr_nxt   = 1'b1;
                        state_nxt    = WR;
                    end else begin
                        base_nxt   = ld_addr_in;
                        len_nxt    = len_to_n(ld_len_in);
                        ram_a_nxt  = ld_addr_in;
                        ram_wr_nxt = 1'b0;
                        state_nxt  = RD;
                    end
                end
            end
            RD: begin
                if (is_if && flush_in) begin
                    busy_nxt  = 2'b00;
                    state_nxt = TURN;
                end else begin
                    rbuf_nxt = rbuf_cap;
                    cnt_nxt  = k;
                    if (k < len) begin
                        ram_a_nxt = base + ADDR_WIDTH'(k);
                    end else begin
                        if (is_if) begin
                            if_done_nxt = 1'b1;
                            if_data_nxt = rbuf_cap;
                        end else begin
                            ld_done_nxt = 1'b1;
                            ld_data_nxt = rbuf_cap;
                        end
                        busy_nxt  = 2'b00;
                        state_nxt = TURN;
                    end
                end
            end
            WR: begin
                cnt_nxt = k;
                if (k < len) begin
                    ram_a_nxt    = base + ADDR_WIDTH'(k);
                    ram_dout_nxt = 8'(wbuf >> {k[1:0], 3'b000});
                end else begin
                    ram_wr_nxt  = 1'b0;
                    st_done_nxt = 1'b1;
                    busy_nxt    = 2'b00;
                    state_nxt   = TURN;
                end
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            base         <= '0;
            wbuf         <= '0;
            rbuf         <= '0;
            last_data    <= 1'b1;
            is_if        <= 1'b0;
            if_done_out  <= 1'b0;
            ld_done_out  <= 1'b0;
            st_done_out  <= 1'b0;
            if_data_out  <= '0;
            ld_data_out  <= '0;
            ram_a_out    <= '0;
            ram_dout_out <= '0;
            ram_wr_out   <= 1'b0;
            busy_out     <= 2'b00;
        end else if (rdy_in) begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            len          <= len_nxt;
            base         <= base_nxt;
            wbuf         <= wbuf_nxt;
            rbuf         <= rbuf_nxt;
            last_data    <= last_data_nxt;
            is_if        <= is_if_nxt;
            if_done_out  <= if_done_nxt;
            ld_done_out  <= ld_done_nxt;
            st_done_out  <= st_done_nxt;
            if_data_out  <= if_data_nxt;
            ld_data_out  <= ld_data_nxt;
            ram_a_out    <= ram_a_nxt;
            ram_dout_out <= ram_dout_nxt;
            ram_wr_out   <= ram_wr_nxt;
            busy_out     <= busy_nxt;
        end
    end

endmodule
